// File: rtl/texture_bilinear_sampler.sv
// texture_bilinear_sampler: wraps/clamps a fixed-point coordinate, fetches one or four texels from the cache, and blends them bilinearly.
module texture_bilinear_sampler #(
  parameter int FRAC_BITS = 8,
  parameter int PIXEL_WIDTH_BITS = 32,
  parameter int TEX_W = 256,
  parameter int TEX_H = 256,
  parameter int NUM_MIP_LEVELS = 6,
  localparam int CHANNELS = PIXEL_WIDTH_BITS / 8,
  localparam int MIP_BITS = $clog2(NUM_MIP_LEVELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_s,
  input  logic [31:0]                 in_t,
  input  logic [MIP_BITS-1:0]         in_mip,
  input  logic                        in_clamp,
  input  logic                        in_filter,
  output logic [31:0]                 c_u,
  output logic [31:0]                 c_v,
  output logic [MIP_BITS-1:0]         c_mip,
  output logic                        c_req_valid,
  input  logic                        c_req_ready,
  input  logic [PIXEL_WIDTH_BITS-1:0] c_texel,
  input  logic                        c_texel_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PIXEL_WIDTH_BITS-1:0] out_pixel
);
  localparam int TW = 9 + FRAC_BITS;
  localparam int AW = 10 + 2 * FRAC_BITS;
  localparam logic [AW-1:0] RND = AW'(1) << (2 * FRAC_BITS - 1);
  localparam logic [MIP_BITS-1:0] MAX_MIP = MIP_BITS'(NUM_MIP_LEVELS - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, BLEND, OUT} state_t;
  state_t state_q, state_d;
  logic [1:0] k_q, k_d;
  logic fl_q, fl_d;
  logic [31:0] u0_q, u0_d, u1_q, u1_d, v0_q, v0_d, v1_q, v1_d;
  logic [FRAC_BITS-1:0] fu_q, fu_d, fv_q, fv_d;
  logic [PIXEL_WIDTH_BITS-1:0] t_q [4];
  logic [PIXEL_WIDTH_BITS-1:0] t_d [4];
  logic [31:0] c_u_q, c_u_d, c_v_q, c_v_d;
  logic [MIP_BITS-1:0] c_mip_q, c_mip_d;
  logic [PIXEL_WIDTH_BITS-1:0] out_pixel_q, out_pixel_d;
  logic [MIP_BITS-1:0] m_c;
  logic [32:0] w_c, h_c, wm1_c, hm1_c, iu0_c, iu1_c, iv0_c, iv1_c;
  logic [31:0] au0_c, au1_c, av0_c, av1_c;
  logic [FRAC_BITS:0] wa, wb, wc, wd;
  logic [PIXEL_WIDTH_BITS-1:0] blend_c;
  // iu+1 is formed in 33 bits so an all-ones integer part clamps rather than wrapping to 0
  function automatic logic [31:0] addr_mode(input logic [32:0] x, input logic [32:0] lim, input logic cl);
    return 32'(cl ? ((x > lim) ? lim : x) : (x & lim));
  endfunction
  always_comb begin
    m_c = (in_mip > MAX_MIP) ? MAX_MIP : in_mip;
    w_c = 33'(TEX_W) >> m_c;
    h_c = 33'(TEX_H) >> m_c;
    wm1_c = (w_c == 33'd0) ? 33'd0 : w_c - 33'd1;
    hm1_c = (h_c == 33'd0) ? 33'd0 : h_c - 33'd1;
    iu0_c = 33'(in_s >> FRAC_BITS);
    iv0_c = 33'(in_t >> FRAC_BITS);
    iu1_c = iu0_c + 33'd1;
    iv1_c = iv0_c + 33'd1;
    au0_c = addr_mode(iu0_c, wm1_c, in_clamp);
    au1_c = addr_mode(iu1_c, wm1_c, in_clamp);
    av0_c = addr_mode(iv0_c, hm1_c, in_clamp);
    av1_c = addr_mode(iv1_c, hm1_c, in_clamp);
    wb = {1'b0, fu_q};
    wd = {1'b0, fv_q};
    wa = {1'b1, {FRAC_BITS{1'b0}}} - wb;
    wc = {1'b1, {FRAC_BITS{1'b0}}} - wd;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [TW-1:0] top, bot;
    logic [AW-1:0] acc;
    assign top = TW'(t_q[0][c*8 +: 8]) * TW'(wa) + TW'(t_q[1][c*8 +: 8]) * TW'(wb);
    assign bot = TW'(t_q[2][c*8 +: 8]) * TW'(wa) + TW'(t_q[3][c*8 +: 8]) * TW'(wb);
    assign acc = AW'(top) * AW'(wc) + AW'(bot) * AW'(wd) + RND;
    assign blend_c[c*8 +: 8] = 8'(acc >> (2 * FRAC_BITS));
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    fl_d = fl_q;
    u0_d = u0_q;
    u1_d = u1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    fu_d = fu_q;
    fv_d = fv_q;
    t_d = t_q;
    c_u_d = c_u_q;
    c_v_d = c_v_q;
    c_mip_d = c_mip_q;
    out_pixel_d = out_pixel_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = REQ;
        k_d = 2'd0;
        fl_d = in_filter;
        u0_d = au0_c;
        u1_d = au1_c;
        v0_d = av0_c;
        v1_d = av1_c;
        fu_d = in_s[FRAC_BITS-1:0];
        fv_d = in_t[FRAC_BITS-1:0];
        c_u_d = au0_c;
        c_v_d = av0_c;
        c_mip_d = m_c;
      end
      REQ: state_d = c_req_ready ? WAIT : REQ;
      WAIT: if (c_texel_valid) begin
        t_d[k_q] = c_texel;
        if (!fl_q || k_q == 2'd3) state_d = BLEND;
        else begin
          state_d = REQ;
          k_d = k_q + 2'd1;
          c_u_d = k_d[0] ? u1_q : u0_q;
          c_v_d = k_d[1] ? v1_q : v0_q;
        end
      end
      BLEND: begin
        out_pixel_d = fl_q ? blend_c : t_q[0];
        state_d = OUT;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      fl_q <= 1'b0;
      u0_q <= '0;
      u1_q <= '0;
      v0_q <= '0;
      v1_q <= '0;
      fu_q <= '0;
      fv_q <= '0;
      t_q <= '{default: '0};
      c_u_q <= '0;
      c_v_q <= '0;
      c_mip_q <= '0;
      out_pixel_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      fl_q <= fl_d;
      u0_q <= u0_d;
      u1_q <= u1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      fu_q <= fu_d;
      fv_q <= fv_d;
      t_q <= t_d;
      c_u_q <= c_u_d;
      c_v_q <= c_v_d;
      c_mip_q <= c_mip_d;
      out_pixel_q <= out_pixel_d;
    end
  end
  assign in_ready = (state_q == IDLE) && !rst;
  assign c_req_valid = state_q == REQ;
  assign out_valid = state_q == OUT;
  assign c_u = c_u_q;
  assign c_v = c_v_q;
  assign c_mip = c_mip_q;
  assign out_pixel = out_pixel_q;
endmodule

// File: tb/tb_texture_bilinear_sampler.sv
// tb_texture_bilinear_sampler: randomized and directed samples checked against a behavioural address/blend model.
module tb_texture_bilinear_sampler;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 0, in_ready, in_clamp = 0, in_filter = 0;
  logic [31:0] in_s = 0, in_t = 0, c_u, c_v;
  logic [2:0] in_mip = 0, c_mip;
  logic c_req_valid, c_req_ready = 0, c_texel_valid = 0, out_valid, out_ready = 0;
  logic [31:0] c_texel = 0, out_pixel;

  texture_bilinear_sampler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s), .in_t(in_t),
    .in_mip(in_mip), .in_clamp(in_clamp), .in_filter(in_filter), .c_u(c_u), .c_v(c_v), .c_mip(c_mip),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_texel(c_texel), .c_texel_valid(c_texel_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
  );

  int n_cmp = 0, n_fail = 0;
  logic [31:0] exp_u [4], exp_v [4], exp_pix, tex [4];
  logic [2:0] exp_m = 0;
  int exp_nf = 0, fk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint ref_addr(input longint x, input longint w, input bit cl);
    return cl ? ((x > w - 1) ? w - 1 : x) : x % w;
  endfunction

  function automatic logic [31:0] ref_blend(input int fu, input int fv);
    logic [31:0] r;
    longint p, q;
    for (int ch = 0; ch < 4; ch++) begin
      p = longint'((tex[0] >> (8 * ch)) & 255) * (256 - fu) + longint'((tex[1] >> (8 * ch)) & 255) * fu;
      q = longint'((tex[2] >> (8 * ch)) & 255) * (256 - fu) + longint'((tex[3] >> (8 * ch)) & 255) * fu;
      r[8 * ch +: 8] = 8'((p * (256 - fv) + q * fv + 32768) / 65536);
    end
    return r;
  endfunction

  task automatic model(input logic [31:0] s, input logic [31:0] t, input logic [2:0] mip, input bit cl, input bit fl);
    longint m, w, h, iu, iv, u0, u1, v0, v1;
    m = (mip > 5) ? 5 : mip;
    w = 256 >> m;
    h = 256 >> m;
    if (w < 1) w = 1;
    if (h < 1) h = 1;
    iu = longint'(s) / 256;
    iv = longint'(t) / 256;
    u0 = ref_addr(iu, w, cl);
    u1 = ref_addr(iu + 1, w, cl);
    v0 = ref_addr(iv, h, cl);
    v1 = ref_addr(iv + 1, h, cl);
    exp_u = '{32'(u0), 32'(u1), 32'(u0), 32'(u1)};
    exp_v = '{32'(v0), 32'(v0), 32'(v1), 32'(v1)};
    exp_m = 3'(m);
    exp_nf = fl ? 4 : 1;
    exp_pix = fl ? ref_blend(int'(s % 256), int'(t % 256)) : tex[0];
  endtask

  // compares every request and every presented pixel against the model
  always @(negedge clk) begin
    if (rst || (in_valid && in_ready)) fk = 0;
    else begin
      if (c_req_valid) begin
        if (fk >= exp_nf) chk("extra_fetch", 64'(fk), 64'(exp_nf));
        else begin
          chk("c_u", c_u, exp_u[fk]);
          chk("c_v", c_v, exp_v[fk]);
          chk("c_mip", c_mip, exp_m);
        end
        if (c_req_ready) fk++;
      end
      if (out_valid) begin
        chk("out_pixel", out_pixel, exp_pix);
        chk("fetch_count", 64'(fk), 64'(exp_nf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tex(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    tex = '{a, b, c, d};
  endtask

  task automatic handshake(input logic [31:0] s, input logic [31:0] t, input logic [2:0] mip, input bit cl, input bit fl);
    int n = 0;
    model(s, t, mip, cl, fl);
    while (!in_ready && n < 50) begin step(); n++; end
    chk("in_ready", in_ready, 1);
    in_s = s; in_t = t; in_mip = mip; in_clamp = cl; in_filter = fl; in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] t, input logic [2:0] mip, input bit cl, input bit fl,
                     input int rq_stall, input int tx_delay, input int o_stall, input bit stray, input int exp_lat);
    int n = 0, w;
    handshake(s, t, mip, cl, fl);
    for (int f = 0; f < exp_nf; f++) begin
      w = 0;
      while (!c_req_valid && w < 50) begin step(); w++; n++; end
      if (!c_req_valid) begin chk("req_timeout", 0, 1); break; end
      for (int i = 0; i < rq_stall; i++) begin
        c_texel_valid = stray && i == 0;
        c_texel = 32'hDEADBEEF;
        step(); n++;
      end
      c_texel_valid = 0;
      c_req_ready = 1; step(); n++; c_req_ready = 0;
      repeat (tx_delay) begin step(); n++; end
      c_texel = tex[f]; c_texel_valid = 1; step(); n++; c_texel_valid = 0;
    end
    w = 0;
    while (!out_valid && w < 50) begin step(); w++; n++; end
    chk("out_valid", out_valid, 1);
    if (exp_lat > 0) chk("latency", 64'(n + 2), 64'(exp_lat));
    repeat (o_stall) step();
    out_ready = 1; step(); out_ready = 0;
    chk("in_ready_after_out", in_ready, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_c_req_valid", c_req_valid, 0);
    chk("rst_c_u", c_u, 0);
    chk("rst_c_v", c_v, 0);
    chk("rst_c_mip", c_mip, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    rst = 0;
    step();
    set_tex(32'h10203040, 32'h10203040, 32'h10203040, 32'h10203040);
    run(32'h00000A00, 32'h00000500, 0, 0, 1, 0, 0, 0, 0, 11);
    chk("model_u0", exp_u[0], 10); chk("model_u1", exp_u[1], 11);
    chk("model_v2", exp_v[2], 6); chk("model_pix1", exp_pix, 32'h10203040);
    set_tex(32'h0, 32'hFF, 32'h0, 32'hFF);
    run(32'h00000A80, 32'h00000500, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("model_pix2", exp_pix, 32'h80);
    set_tex($urandom, $urandom, $urandom, $urandom);
    run(32'h00003F40, 32'h00000100, 2, 0, 1, 0, 1, 0, 0, 0);
    chk("model_rep_u0", exp_u[0], 63); chk("model_rep_u1", exp_u[1], 0);
    run(32'h00003F40, 32'h00000100, 2, 1, 1, 0, 0, 0, 0, 0);
    chk("model_clamp_u1", exp_u[1], 63);
    run(32'h00FFFF80, 32'h00000100, 2, 1, 1, 1, 0, 0, 0, 0);
    chk("model_clamp_big", exp_u[1], 63);
    run(32'hFFFFFF80, 32'hFFFFFF80, 2, 1, 1, 0, 0, 0, 0, 0);
    chk("model_clamp_max", exp_u[1], 63);
    run(32'h12345678, 32'h9ABCDEF0, 7, 0, 0, 0, 0, 0, 0, 5);
    chk("model_nearest_m", exp_m, 5); chk("model_nearest_u", exp_u[0], 6);
    chk("model_nearest_v", exp_v[0], 6); chk("model_nearest_pix", exp_pix, tex[0]);
    set_tex($urandom, $urandom, $urandom, $urandom);
    run(32'h00051234, 32'h00029876, 1, 0, 1, 3, 0, 0, 1, 0);
    run(32'h0007F0C0, 32'h00000140, 0, 1, 1, 0, 2, 5, 0, 0);
    // reset while waiting for fetch 1's texel
    set_tex($urandom, $urandom, $urandom, $urandom);
    handshake(32'h00001400, 32'h00000C00, 0, 0, 1);
    c_req_ready = 1; step(); c_req_ready = 0;
    c_texel = tex[0]; c_texel_valid = 1; step(); c_texel_valid = 0;
    chk("pre_rst_req", c_req_valid, 1);
    c_req_ready = 1; step(); c_req_ready = 0;
    rst = 1; step();
    chk("in_ready_in_rst", in_ready, 0);
    rst = 0; #1;
    chk("in_ready_post_rst", in_ready, 1);
    c_texel = tex[1]; c_texel_valid = 1; step(); c_texel_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_req", c_req_valid, 0);
      step();
    end
    set_tex($urandom, $urandom, $urandom, $urandom);
    run(32'h00002A33, 32'h00001177, 0, 0, 1, 0, 0, 0, 0, 11);
    for (int i = 0; i < 60; i++) begin
      set_tex($urandom, $urandom, $urandom, $urandom);
      run($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/texture_bilinear_sampler.md
# texture_bilinear_sampler

Sampling stage directly upstream of the tile texture cache, and also the consumer of its texels. It accepts one fixed-point texture coordinate per transaction. It applies the address mode (repeat or clamp) against the selected mip level's dimensions and issues one or four integer texel fetches to the cache, one outstanding at a time. It then blends the returned texels bilinearly per 8-bit channel and presents one filtered pixel downstream.

## Interface
Parameters:
- FRAC_BITS, 8: fractional bits of input coordinates.
- PIXEL_WIDTH_BITS, 32: texel width; CHANNELS = PIXEL_WIDTH_BITS/8.
- TEX_W, 256: mip-0 width in texels; power of two.
- TEX_H, 256: mip-0 height in texels; power of two.
- NUM_MIP_LEVELS, 6: number of levels; MIP_BITS = $clog2(NUM_MIP_LEVELS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  sample request valid.
- in_ready  out  1  high exactly when the FSM is in IDLE and rst is low.
- in_s  in  32  U coordinate, unsigned, (32-FRAC_BITS).FRAC_BITS, in level-texel units.
- in_t  in  32  V coordinate, same format.
- in_mip  in  MIP_BITS  mip level.
- in_clamp  in  1  1 = clamp-to-edge, 0 = repeat.
- in_filter  in  1  1 = bilinear, 0 = nearest (single fetch).
- c_u, c_v  out  32 each  integer texel coordinate to cache.
- c_mip  out  MIP_BITS  level to cache.
- c_req_valid  out  1  cache request valid.
- c_req_ready  in  1  cache ready.
- c_texel  in  PIXEL_WIDTH_BITS  returned texel.
- c_texel_valid  in  1  one-cycle texel strobe.
- out_valid  out  1  filtered pixel valid.
- out_ready  in  1  downstream ready.
- out_pixel  out  PIXEL_WIDTH_BITS  filtered pixel.

## Operation
Capture and address mode:
- On in_valid && in_ready, capture all inputs.
- Effective mip m = min(in_mip, NUM_MIP_LEVELS-1).
- Level width W = max(TEX_W>>m, 1); level height H = max(TEX_H>>m, 1).
- Integer parts: iu = in_s>>FRAC_BITS, iv = in_t>>FRAC_BITS. Fractions: fu = in_s[FRAC_BITS-1:0], fv likewise.
- u0 from iu, u1 from iu+1. Compute iu+1 in 33-FRAC_BITS bits, so iu = all-ones does not wrap to 0 before the address mode is applied.
- Repeat: x & (W-1). Clamp: min(x, W-1). v0 and v1 use the same rules with iv and H.

Fetch order:
- Bilinear: t00 at (u0,v0), t10 at (u1,v0), t01 at (u0,v1), t11 at (u1,v1).
- Nearest: t00 only.
- c_mip = m for every fetch.

FSM states:
- IDLE: wait for handshake; go to REQ.
- REQ: c_req_valid=1, c_u/c_v set for fetch k. Go to WAIT on c_req_valid && c_req_ready.
- WAIT: c_req_valid=0. On c_texel_valid, store the texel in slot k.
  - If more fetches remain, k++ and go to REQ.
  - Otherwise go to BLEND.
- BLEND: one cycle; compute and register out_pixel. Go to OUT.
- OUT: out_valid=1. On out_ready, go to IDLE.

Cache-side rules:
- c_u, c_v and c_mip are stable from REQ entry until the matching c_texel_valid.
- At most one outstanding request.
- c_texel_valid outside WAIT is ignored.

Blend arithmetic, per channel ch (8-bit, unsigned):
- Weights: a = 2^F - fu, b = fu, c = 2^F - fv, d = fv, where F = FRAC_BITS. Weights are F+1 bits.
- top = t00·a + t10·b; bot = t01·a + t11·b. Each is 9+F bits.
- res = (top·c + bot·d + 2^(2F-1)) >> 2F. Accumulate in 10+2F bits; the result is in 0..255, with no saturation needed.
- Nearest mode: out_pixel = t00 exactly.

## Timing
- Reset values: state IDLE, in_ready=0 while rst high, c_req_valid=0, c_u=c_v=0, c_mip=0, out_valid=0, out_pixel=0, k=0.
- Per-fetch sequence:
  - Cycle N: handshake in IDLE.
  - N+1: REQ with c_req_valid high; all request outputs are registered.
  - REQ exits the cycle after c_req_ready is sampled high.
  - WAIT ends on the c_texel_valid cycle.
  - The next REQ, or BLEND, follows in the next cycle.
- Latency from input handshake to out_valid = 1 + Σ(REQ+WAIT cycles) + 1 (BLEND) + 1.
  - With zero-wait cache cycles this is minimum 1 + 4·2 + 2 for bilinear and 1 + 2 + 2 for nearest.
- out_valid and out_pixel hold stable while out_ready=0. in_ready stays low until IDLE is re-entered.
- rst in any state returns the FSM to IDLE next cycle and discards captured data.
  - A cache response arriving after reset is ignored.

## Test plan
- TEX_W=TEX_H=256, mip 0, repeat, bilinear, in_s=0x00000A00, in_t=0x00000500; cache returns 0x10203040 for all fetches → (c_u,c_v) sequence (10,5),(11,5),(10,6),(11,6), c_mip=0; out_pixel=0x10203040.
- in_s=0x00000A80 (10.5), in_t=0x00000500; t00=t01=0x00000000, t10=t11=0x000000FF → out_pixel=0x00000080.
- mip=2 (W=64), repeat, in_s=0x00003F40 (63.25) → u0=63, u1=0. With clamp: u0=u1=63. Clamp with in_s=0x00FFFF80 → u0=u1=63, with no +1 wrap to 0.
- in_filter=0, in_mip=7 → c_mip=5, one fetch at (iu & 7, iv & 7) in repeat mode; out_pixel equals the returned texel bit-exactly.
- Cache holds c_req_ready=0 for 3 cycles, and c_texel_valid is pulsed during REQ → c_u/c_v/c_req_valid stay stable, the stray strobe is ignored, and 4 texels are stored in order.
- out_ready low for 5 cycles → out_valid and out_pixel hold. Separately, rst pulsed in WAIT of fetch 1, then c_texel_valid arrives → out_valid stays 0, in_ready=1 after rst falls, and the next sample completes correctly.
